// File: rtl/imm_instr_encoder_pkg.sv
// Shared definitions for the immediate encoder and the pipeline's immediate extractor.
// Both ends use the same opcode[6:5] format map.
package imm_instr_encoder_pkg;

    localparam logic [1:0] FMT_I = 2'b00;
    localparam logic [1:0] FMT_S = 2'b01;
    localparam logic [1:0] FMT_B = 2'b11;

    localparam int INSTR_W = 32;

    typedef struct packed {
        logic               err;
        logic [INSTR_W-1:0] instr;
    } fifo_entry_t;

    // A 64-bit immediate fits signed 12 bits when bits [63:11] are a pure sign extension.
    function automatic logic imm_fits_12(input logic [63:0] imm);
        return (&imm[63:11]) || !(|imm[63:11]);
    endfunction

endpackage

// File: rtl/imm_instr_encoder_sync_fifo.sv
// Single-clock FIFO with an occupancy counter; the read port shows zero while empty.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; empty masks stale contents and this keeps it plain RAM.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/imm_instr_encoder.sv
// Packs opcode, register fields and an immediate into an I/S/B-type word, queues it,
// and tags the queue head with a sequential word address.
module imm_instr_encoder
    import imm_instr_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [63:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_count
);

    fifo_entry_t       enc_entry;
    fifo_entry_t       head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              dequeue;
    logic [11:0]       imm12;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        err_count_q, err_count_d;

    assign imm12   = in_imm[11:0];
    assign accept  = in_valid && !fifo_full;
    assign dequeue = !fifo_empty && out_ready;

    // B-type immediates arrive in halfword units, so imm12[0] already lands in word bit 8.
    always_comb begin
        enc_entry = '0;
        case (in_opcode[6:5])
            FMT_I: enc_entry.instr = {imm12, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: enc_entry.instr = {imm12[11:5], in_rs2, in_rs1, in_funct3,
                                      imm12[4:0], in_opcode};
            FMT_B: enc_entry.instr = {imm12[11], imm12[9:4], in_rs2, in_rs1, in_funct3,
                                      imm12[3:0], imm12[10], in_opcode};
            default: enc_entry.err = 1'b1;
        endcase
        if (!imm_fits_12(in_imm)) begin
            enc_entry.err = 1'b1;
        end
        if (enc_entry.err) begin
            enc_entry.instr = '0;
        end
    end

    always_comb begin
        addr_d      = addr_q;
        err_count_d = err_count_q;
        if (dequeue) begin
            addr_d = addr_q + 1'b1;
        end
        if (accept && enc_entry.err && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            err_count_q <= '0;
        end else begin
            addr_q      <= addr_d;
            err_count_q <= err_count_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (accept),
        .wr_data (enc_entry),
        .rd_en   (dequeue),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign out_instr = head_entry.instr;
    assign out_err   = head_entry.err;
    assign out_addr  = addr_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Randomised and directed bench for imm_instr_encoder against a queue-based reference model.
module tb_imm_instr_encoder;

    localparam int DEPTH = 4;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_opcode;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [63:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_addr;
    logic          out_err;
    logic [7:0]    err_count;

    imm_instr_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint unsigned instr;
        bit              err;
    } exp_t;

    exp_t        model_q[$];
    int unsigned m_addr;
    int unsigned m_errs;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoder built from field weights (powers of two) and signed range arithmetic.
    function automatic exp_t ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [63:0] imm);
        exp_t            e;
        longint          s;
        longint unsigned im, r1, r2, rdv, fv, opv, base;
        s    = longint'(imm);
        im   = longint'(imm) & 64'hFFF;
        r1   = longint'(rs1);
        r2   = longint'(rs2);
        rdv  = longint'(rd);
        fv   = longint'(f3);
        opv  = longint'(op);
        base = r1 * (1 << 15) + fv * (1 << 12) + opv;
        e.err   = (op / 32 == 2) || (s < -2048) || (s > 2047);
        e.instr = 0;
        if (!e.err) begin
            case (op / 32)
                0: e.instr = im * (1 << 20) + base + rdv * (1 << 7);
                1: e.instr = (im / 32) * (1 << 25) + r2 * (1 << 20) + base + (im % 32) * (1 << 7);
                default: e.instr = (im / 2048) * (longint'(1) << 31) + ((im / 16) % 64) * (1 << 25)
                                 + r2 * (1 << 20) + base + (im % 16) * (1 << 8)
                                 + ((im / 1024) % 2) * (1 << 7);
            endcase
        end
        return e;
    endfunction

    function automatic logic [63:0] extract_s(input logic [31:0] w);
        logic [11:0] b;
        b = {w[31:25], w[11:7]};
        return {{52{b[11]}}, b};
    endfunction

    function automatic logic [63:0] extract_b(input logic [31:0] w);
        logic [11:0] b;
        b = {w[31], w[7], w[30:25], w[11:8]};
        return {{52{b[11]}}, b};
    endfunction

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [63:0] imm);
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_imm    = imm;
    endtask

    // Compare outputs against the model, then advance one clock and update the model.
    task automatic step();
        bit   acc, deq;
        exp_t e;
        check("in_ready", in_ready, 64'(model_q.size() < DEPTH));
        check("out_valid", out_valid, 64'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            check("out_instr", out_instr, model_q[0].instr);
            check("out_err", out_err, 64'(model_q[0].err));
            check("out_addr", out_addr, 64'(m_addr));
        end
        check("err_count", err_count, 64'(m_errs));
        acc = in_valid && (model_q.size() < DEPTH);
        deq = out_ready && (model_q.size() != 0);
        e   = ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
        @(posedge clk);
        if (reset) begin
            model_q.delete();
            m_addr = 0;
            m_errs = 0;
        end else begin
            if (deq) begin
                void'(model_q.pop_front());
                m_addr = (m_addr + 1) % (1 << AW);
            end
            if (acc) begin
                model_q.push_back(e);
                if (e.err && m_errs < 255) m_errs++;
            end
        end
        #1;
    endtask

    initial begin
        longint bnd[4] = '{-2049, -2048, 2047, 2048};
        logic [1:0] fmt;
        int pushed, got_addr, cyc;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        model_q.delete();
        m_addr = 0;
        m_errs = 0;
        reset  = 1'b0;
        check("rst_out_valid", out_valid, 64'd0);
        check("rst_in_ready", in_ready, 64'd1);
        check("rst_out_instr", out_instr, 64'd0);
        check("rst_out_addr", out_addr, 64'd0);
        check("rst_out_err", out_err, 64'd0);
        check("rst_err_count", err_count, 64'd0);

        // I-type, imm = -1
        drive(7'b0010011, 5'd5, 5'd6, 5'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("i_instr", out_instr, 64'hFFF30293);
        check("i_err", out_err, 64'd0);
        check("i_addr", out_addr, 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // S-type, imm = 16
        drive(7'b0100011, 5'd0, 5'd2, 5'd8, 3'd3, 64'd16);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("s_instr", out_instr, 64'h00813823);
        check("s_roundtrip", extract_s(out_instr), 64'd16);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // B-type, imm = -2 halfwords
        drive(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("b_roundtrip", extract_b(out_instr), 64'hFFFF_FFFF_FFFF_FFFE);
        check("b_err", out_err, 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Range error then illegal format
        drive(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 64'd2048);
        in_valid = 1'b1;
        step();
        drive(7'b1000011, 5'd1, 5'd1, 5'd1, 3'd0, 64'd0);
        step();
        in_valid = 1'b0;
        check("err1_flag", out_err, 64'd1);
        check("err1_instr", out_instr, 64'd0);
        out_ready = 1'b1;
        step();
        check("err2_flag", out_err, 64'd1);
        check("err2_instr", out_instr, 64'd0);
        check("err_count_2", err_count, 64'd2);
        step();
        out_ready = 1'b0;

        // Backpressure from a fresh address counter
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(7'b0010011, 5'd3, 5'd4, 5'd0, 3'd1, 64'd100);
        in_valid = 1'b1;
        pushed   = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_valid && in_ready) pushed++;
            step();
        end
        check("bp_pushed", 64'(pushed), 64'd4);
        check("bp_in_ready", in_ready, 64'd0);
        out_ready = 1'b1;
        got_addr  = 0;
        cyc       = 0;
        while (got_addr < 5 && cyc < 20) begin
            if (out_valid) begin
                check("bp_addr_order", out_addr, 64'(got_addr));
                got_addr++;
            end
            if (in_valid && in_ready) begin
                pushed++;
                if (pushed == 5) begin
                    step();
                    in_valid = 1'b0;
                    cyc++;
                    continue;
                end
            end
            step();
            cyc++;
        end
        if (got_addr < 5) check("bp_timeout", 64'(got_addr), 64'd5);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset with three entries queued
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(7'b1000011, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
        in_valid = 1'b1;
        step();
        drive(7'b0100011, 5'd0, 5'd7, 5'd9, 3'd2, 64'h7FF);
        step();
        step();
        in_valid = 1'b0;
        check("pre_rst_err_count", err_count, 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_out_valid", out_valid, 64'd0);
        check("mid_rst_err_count", err_count, 64'd0);
        drive(7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 64'd7);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_rst_addr", out_addr, 64'd0);
        check("post_rst_valid", out_valid, 64'd1);

        // Randomised traffic with range boundaries and all formats
        for (int i = 0; i < 500; i++) begin
            fmt = 2'($urandom_range(0, 3));
            drive({fmt, 5'($urandom)}, 5'($urandom), 5'($urandom), 5'($urandom),
                  3'($urandom), 64'd0);
            case ($urandom_range(0, 4))
                0:       in_imm = {$urandom, $urandom};
                1:       in_imm = bnd[$urandom_range(0, 3)];
                default: in_imm = longint'($urandom_range(0, 4095)) - 2048;
            endcase
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end

        // Error counter saturation and address wrap
        drive(7'b1000011, 5'd0, 5'd0, 5'd0, 3'd0, 64'd0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) step();
        check("err_count_sat", err_count, 64'hFF);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
